// File: rtl/crc16_frame_checker_if.sv
// crc16_frame_checker_if: byte stream in, payload stream plus per-frame CRC result out
interface crc16_frame_checker_if #(parameter int CNT_W = 16);
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_last;
    logic             flush;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_last;
    logic             frame_done;
    logic             crc_ok;
    logic             runt;
    logic [CNT_W-1:0] good_count;
    logic [CNT_W-1:0] bad_count;
    modport master (
        output s_valid, s_data, s_last, flush,
        input  m_valid, m_data, m_last, frame_done, crc_ok, runt, good_count, bad_count
    );
    modport slave (
        input  s_valid, s_data, s_last, flush,
        output m_valid, m_data, m_last, frame_done, crc_ok, runt, good_count, bad_count
    );
endinterface

// File: rtl/crc16_frame_checker.sv
// crc16_frame_checker: strips trailing CRC16-CCITT bytes, forwards payload, reports residue check per frame
module crc16_frame_checker #(
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    crc16_frame_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HAVE1, STREAM} state_t;
    state_t      state, state_nx;
    logic [15:0] crc, crc_nx;
    logic [7:0]  b0, b1;
    logic        acc, fin, emit, ok_nx, runt_nx;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        return x;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = bus.flush ? IDLE :
                   !bus.s_valid ? state :
                   bus.s_last ? IDLE :
                   state == IDLE ? HAVE1 : STREAM;
    end

    // A frame starting in IDLE seeds from 0xFFFF directly, so back-to-back frames need no idle clk
    always_comb begin
        acc     = bus.s_valid && !bus.flush;
        crc_nx  = crc_step(state == IDLE ? 16'hFFFF : crc, bus.s_data);
        fin     = acc && bus.s_last;
        emit    = acc && state == STREAM;
        ok_nx   = fin && state == STREAM && crc_nx == 16'h0000;
        runt_nx = fin && state != STREAM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc            <= 16'hFFFF;
            b0             <= 8'h00;
            b1             <= 8'h00;
            bus.m_valid    <= 1'b0;
            bus.m_data     <= 8'h00;
            bus.m_last     <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.crc_ok     <= 1'b0;
            bus.runt       <= 1'b0;
            bus.good_count <= '0;
            bus.bad_count  <= '0;
        end else begin
            crc            <= (bus.flush || fin) ? 16'hFFFF : acc ? crc_nx : crc;
            b0             <= acc ? b1 : b0;
            b1             <= acc ? bus.s_data : b1;
            bus.m_valid    <= emit;
            bus.m_data     <= emit ? b0 : 8'h00;
            bus.m_last     <= emit && bus.s_last;
            bus.frame_done <= fin;
            bus.crc_ok     <= ok_nx;
            bus.runt       <= runt_nx;
            if (fin && ok_nx && bus.good_count != {CNT_W{1'b1}})
                bus.good_count <= bus.good_count + 1'b1;
            if (fin && !ok_nx && bus.bad_count != {CNT_W{1'b1}})
                bus.bad_count <= bus.bad_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_crc16_frame_checker.sv
// tb_crc16_frame_checker: frame-level reference model, directed scenarios, then randomized frames
module tb_crc16_frame_checker;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MAXC = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc16_frame_checker_if #(.CNT_W(CNT_W)) bus();
    crc16_frame_checker #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef logic [7:0] bq_t[$];
    bq_t fq;
    bq_t frm;
    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    logic             exp_mv = 1'b0, exp_ml = 1'b0, exp_fd = 1'b0, exp_ok = 1'b0, exp_rn = 1'b0;
    logic [7:0]       exp_md = 8'h00;
    logic [CNT_W-1:0] exp_good = '0, exp_bad = '0;

    // Bit-serial CRC over a whole frame
    function automatic logic [15:0] crc_of(input bq_t q);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[k])
            for (int i = 7; i >= 0; i--)
                c = {c[14:0], 1'b0} ^ (((c[15] ^ q[k][i]) == 1'b1) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: collect the frame's bytes; payload byte j is due when byte j+2 arrives
    always @(posedge clk) begin : mdl
        logic mv, ml, fd, ok, rn;
        logic [7:0] md;
        mv = 1'b0; ml = 1'b0; fd = 1'b0; ok = 1'b0; rn = 1'b0; md = 8'h00;
        if (rst) begin
            fq.delete();
            exp_good <= '0;
            exp_bad  <= '0;
        end else if (bus.flush) begin
            fq.delete();
        end else if (bus.s_valid) begin
            fq.push_back(bus.s_data);
            if (fq.size() >= 3) begin
                mv = 1'b1;
                md = fq[fq.size()-3];
                ml = bus.s_last;
            end
            if (bus.s_last) begin
                fd = 1'b1;
                rn = fq.size() < 3;
                ok = !rn && crc_of(fq) == 16'h0000;
                fq.delete();
                if (ok && exp_good != MAXC) exp_good <= exp_good + 1'b1;
                if (!ok && exp_bad != MAXC) exp_bad <= exp_bad + 1'b1;
            end
        end
        exp_mv <= mv; exp_md <= md; exp_ml <= ml;
        exp_fd <= fd; exp_ok <= ok; exp_rn <= rn;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", bus.m_valid, exp_mv);
            chk("m_last", bus.m_last, exp_ml);
            chk("frame_done", bus.frame_done, exp_fd);
            if (exp_mv) chk("m_data", bus.m_data, exp_md);
            if (exp_fd) begin
                chk("crc_ok", bus.crc_ok, exp_ok);
                chk("runt", bus.runt, exp_rn);
            end
            chk("good_count", bus.good_count, exp_good);
            chk("bad_count", bus.bad_count, exp_bad);
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic f);
        @(posedge clk);
        #1;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.flush   = f;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic send_frame(input int gapmax, input int flush_at);
        for (int k = 0; k < frm.size(); k++) begin
            if (gapmax > 0) idle($urandom_range(gapmax, 0));
            if (k == flush_at) begin
                cyc(1'($urandom), frm[k], 1'($urandom), 1'b1);
                return;
            end
            cyc(1'b1, frm[k], k == frm.size() - 1, 1'b0);
        end
    endtask

    task automatic make_good();
        logic [15:0] c;
        c = crc_of(frm);
        frm.push_back(c[15:8]);
        frm.push_back(c[7:0]);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        bus.flush   = 1'b0;
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_check_value", crc_of(frm), 16'h29B1);
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
        chk("model_residue", crc_of(frm), 16'h0000);
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #1 rst = 1'b0;
        send_frame(0, -1);
        idle(3);
        chk("t1_good", bus.good_count, 1);
        frm[4] = 8'h36;
        send_frame(0, -1);
        idle(3);
        chk("t2_bad", bus.bad_count, 1);
        chk("t2_good", bus.good_count, 1);
        frm[4] = 8'h35;
        send_frame(0, -1);
        send_frame(0, -1);
        idle(3);
        chk("t3_good", bus.good_count, 3);
        frm = '{8'hAA};
        send_frame(0, -1);
        frm = '{8'hAA, 8'hBB};
        send_frame(0, -1);
        idle(3);
        chk("t4_bad", bus.bad_count, 3);
        frm = '{8'h00};
        make_good();
        send_frame(3, -1);
        idle(5);
        chk("t5_good", bus.good_count, 4);
        frm = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(0, 4);
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
        send_frame(0, -1);
        idle(3);
        chk("t6_flush_good", bus.good_count, 5);
        chk("t6_flush_bad", bus.bad_count, 3);
        for (int k = 0; k < 3; k++) cyc(1'b1, frm[k], 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_rst_good", bus.good_count, 0);
        chk("t6_rst_bad", bus.bad_count, 0);
        send_frame(0, -1);
        idle(3);
        chk("t6_after_rst", bus.good_count, 1);
        for (int n = 0; n < 150; n++) begin
            int p;
            p = $urandom_range(8, 0);
            frm.delete();
            for (int k = 0; k < p; k++) frm.push_back(8'($urandom));
            if ($urandom % 3 != 0) make_good();
            else begin
                frm.push_back(8'($urandom));
                frm.push_back(8'($urandom));
            end
            send_frame(($urandom % 2 == 1) ? 2 : 0,
                       ($urandom % 10 == 0) ? int'($urandom_range(frm.size() - 1, 0)) : -1);
        end
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
        repeat (20) send_frame(0, -1);
        frm = '{8'hAA};
        repeat (20) send_frame(0, -1);
        idle(3);
        chk("sat_good", bus.good_count, MAXC);
        chk("sat_bad", bus.bad_count, MAXC);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
